// File: rtl/fetch_align_buffer_if.sv
// Fetch front-end bus: instruction-memory port, EX redirect and the IF/ID delivery handshake.
// The master side is the fetch_align_buffer, the slave side is memory plus the pipeline.
interface fetch_align_buffer_if;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        instr_ready;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        is_compressed;

   modport master (
      output mem_req, mem_addr, instr_valid, instr, instr_pc, is_compressed,
      input  mem_rvalid, mem_rdata, redirect, redirect_pc, instr_ready
   );

   modport slave (
      input  mem_req, mem_addr, instr_valid, instr, instr_pc, is_compressed,
      output mem_rvalid, mem_rdata, redirect, redirect_pc, instr_ready
   );
endinterface

// File: rtl/fetch_align_buffer.sv
// Halfword queue that realigns mixed 16/32-bit RISC-V instructions fetched as 32-bit words.
// One request in flight at a time; redirects flush the queue and discard stale responses.
module fetch_align_buffer #(
   parameter int          DEPTH    = 8,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input logic                  clk,
   input logic                  rst,
   fetch_align_buffer_if.master bus
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] FILL_MAX = CW'(DEPTH - 2);
   localparam logic [PW:0]   DEPTH_W  = (PW + 1)'(DEPTH);

   logic [15:0]   q [DEPTH];
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [CW-1:0] count;
   logic [31:0]   fetch_addr;
   logic [31:0]   out_pc;
   logic          outstanding;
   logic          discard;
   logic          drop_low;

   logic [15:0]   hw0;
   logic [15:0]   hw1;
   logic          head_comp;
   logic          instr_valid_i;
   logic          pop;
   logic [1:0]    pop_n;
   logic          rsp;
   logic          push_en;
   logic [1:0]    push_n;
   logic          issue;
   logic          unused_pc_bit;

   function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [1:0] n);
      logic [PW:0] s;
      s = {1'b0, p} + (PW + 1)'(n);
      if (s >= DEPTH_W) s = s - DEPTH_W;
      return s[PW-1:0];
   endfunction

   // Halfword-aligned target: bit 0 carries no information.
   assign unused_pc_bit = bus.redirect_pc[0];

   assign hw0           = q[head];
   assign hw1           = q[ptr_add(head, 2'd1)];
   assign head_comp     = (hw0[1:0] != 2'b11);
   assign instr_valid_i = (count != '0) && (head_comp || (count >= CW'(2)));

   assign pop     = instr_valid_i && bus.instr_ready;
   assign pop_n   = !pop ? 2'd0 : (head_comp ? 2'd1 : 2'd2);

   // Responses with nothing in flight (e.g. straight after reset) are ignored.
   assign rsp     = bus.mem_rvalid && outstanding;
   assign push_en = rsp && !discard && !bus.redirect;
   assign push_n  = !push_en ? 2'd0 : (drop_low ? 2'd1 : 2'd2);

   // Issue only while two free slots are guaranteed for the returning word.
   assign issue = rst && !outstanding && (count <= FILL_MAX) && !bus.redirect;

   assign bus.mem_req       = issue;
   assign bus.mem_addr      = issue ? fetch_addr : 32'h0;
   assign bus.instr_valid   = instr_valid_i;
   assign bus.instr         = !instr_valid_i ? 32'h0 :
                              (head_comp ? {16'h0000, hw0} : {hw1, hw0});
   assign bus.instr_pc      = out_pc;
   assign bus.is_compressed = instr_valid_i && head_comp;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head        <= '0;
         tail        <= '0;
         count       <= '0;
         fetch_addr  <= {RESET_PC[31:2], 2'b00};
         out_pc      <= RESET_PC;
         outstanding <= 1'b0;
         discard     <= 1'b0;
         drop_low    <= 1'b0;
      end else if (bus.redirect) begin
         head        <= '0;
         tail        <= '0;
         count       <= '0;
         out_pc      <= {bus.redirect_pc[31:1], 1'b0};
         fetch_addr  <= {bus.redirect_pc[31:2], 2'b00};
         drop_low    <= bus.redirect_pc[1];
         // A response landing this cycle is dropped now; otherwise the next one is stale.
         outstanding <= outstanding && !bus.mem_rvalid;
         discard     <= outstanding && !bus.mem_rvalid;
      end else begin
         head  <= ptr_add(head, pop_n);
         tail  <= ptr_add(tail, push_n);
         count <= count + CW'(push_n) - CW'(pop_n);
         if (pop) out_pc <= out_pc + (head_comp ? 32'd2 : 32'd4);
         if (issue) begin
            outstanding <= 1'b1;
            fetch_addr  <= fetch_addr + 32'd4;
         end else if (rsp) begin
            outstanding <= 1'b0;
         end
         if (rsp) begin
            discard <= 1'b0;
            if (!discard) drop_low <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) q[i] <= '0;
      end else if (push_en) begin
         if (drop_low) begin
            q[tail] <= bus.mem_rdata[31:16];
         end else begin
            q[tail]                <= bus.mem_rdata[15:0];
            q[ptr_add(tail, 2'd1)] <= bus.mem_rdata[31:16];
         end
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst) count <= CW'(DEPTH));

endmodule

// File: tb/tb_fetch_align_buffer.sv
// Bench for fetch_align_buffer: latency-programmable memory model plus an expected-instruction
// queue filled as each scenario is set up and drained as instructions are accepted.
module tb_fetch_align_buffer;
   logic clk;
   logic rst;

   fetch_align_buffer_if bus();

   fetch_align_buffer #(.DEPTH(8), .RESET_PC(32'h0000_0000)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [31:0] ins;
      logic [31:0] pc;
      logic        comp;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   int          lat = 1;
   logic [31:0] mem [0:127];
   logic        pend;
   logic [31:0] paddr;
   int          wcnt;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory: request seen in cycle N returns data in cycle N+lat.
   initial begin : mem_model
      pend           = 1'b0;
      paddr          = '0;
      wcnt           = 0;
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = '0;
      forever begin
         @(negedge clk);
         if (!rst) pend = 1'b0;
         else if (bus.mem_req) begin
            pend  = 1'b1;
            paddr = bus.mem_addr;
            wcnt  = lat;
         end
         @(posedge clk);
         #1;
         bus.mem_rvalid = 1'b0;
         if (pend && rst) begin
            wcnt--;
            if (wcnt == 0) begin
               bus.mem_rvalid = 1'b1;
               bus.mem_rdata  = mem[paddr[8:2]];
               pend           = 1'b0;
            end
         end
      end
   end

   task automatic fill_mem();
      for (int i = 0; i < 128; i++) mem[i] = 32'h0000_0013 | (32'(i) << 20);
   endtask

   task automatic push_expect(input logic [31:0] ins, input logic [31:0] pc, input logic comp);
      exp_t e;
      e.ins  = ins;
      e.pc   = pc;
      e.comp = comp;
      sb.push_back(e);
   endtask

   // Leaves the bench at posedge+2 of cycle C0, the first cycle out of reset.
   task automatic do_reset();
      rst             = 1'b0;
      bus.redirect    = 1'b0;
      bus.redirect_pc = '0;
      bus.instr_ready = 1'b1;
      sb.delete();
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      @(negedge clk);
      checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req got %b expected 0", bus.mem_req); end
      checks++; if (bus.mem_addr !== 32'h0) begin errors++; $display("FAIL rst_mem_addr got %h expected 0", bus.mem_addr); end
      checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL rst_instr_valid got %b expected 0", bus.instr_valid); end
      checks++; if (bus.instr !== 32'h0) begin errors++; $display("FAIL rst_instr got %h expected 0", bus.instr); end
      checks++; if (bus.instr_pc !== 32'h0) begin errors++; $display("FAIL rst_instr_pc got %h expected 0", bus.instr_pc); end
      checks++; if (bus.is_compressed !== 1'b0) begin errors++; $display("FAIL rst_is_compressed got %b expected 0", bus.is_compressed); end
   endtask

   task automatic test_single();
      exp_t e;
      fill_mem();
      mem[0] = 32'h00A0_0093;
      lat = 1;
      do_reset();
      push_expect(32'h00A0_0093, 32'h0, 1'b0);
      @(negedge clk);
      checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0) begin
         errors++; $display("FAIL single_c0_req got req=%b addr=%h expected req=1 addr=0", bus.mem_req, bus.mem_addr); end
      @(negedge clk);
      checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL single_c1_valid got %b expected 0", bus.instr_valid); end
      @(negedge clk);
      checks++;
      if (bus.instr_valid !== 1'b1) begin
         errors++; $display("FAIL single_c2_valid got %b expected 1", bus.instr_valid);
      end else begin
         e = sb.pop_front();
         if (bus.instr !== e.ins || bus.instr_pc !== e.pc || bus.is_compressed !== e.comp) begin
            errors++; $display("FAIL single_out got instr=%h pc=%h c=%b expected instr=%h pc=%h c=%b",
                               bus.instr, bus.instr_pc, bus.is_compressed, e.ins, e.pc, e.comp);
         end
      end
   endtask

   task automatic test_compressed();
      exp_t e;
      int   n = 0;
      int   fire_cyc[2] = '{-1, -1};
      fill_mem();
      mem[0] = 32'h4505_4505;
      lat = 1;
      do_reset();
      push_expect(32'h0000_4505, 32'h0, 1'b1);
      push_expect(32'h0000_4505, 32'h2, 1'b1);
      push_expect(mem[1], 32'h4, 1'b0);
      for (int c = 0; c < 40 && sb.size() > 0; c++) begin
         @(negedge clk);
         if (bus.instr_valid && bus.instr_ready) begin
            if (n < 2) fire_cyc[n] = c;
            n++;
            checks++;
            if (sb.size() == 0) begin
               errors++; $display("FAIL comp_extra got pc=%h expected no output", bus.instr_pc);
            end else begin
               e = sb.pop_front();
               if (bus.instr !== e.ins || bus.instr_pc !== e.pc || bus.is_compressed !== e.comp) begin
                  errors++; $display("FAIL comp_out got instr=%h pc=%h c=%b expected instr=%h pc=%h c=%b",
                                     bus.instr, bus.instr_pc, bus.is_compressed, e.ins, e.pc, e.comp);
               end
            end
         end
         @(posedge clk); #2;
      end
      checks++; if (sb.size() != 0) begin errors++; $display("FAIL comp_drain got %0d left expected 0", sb.size()); end
      checks++; if (fire_cyc[0] != 2 || fire_cyc[1] != 3) begin
         errors++; $display("FAIL comp_timing got cycles %0d,%0d expected 2,3", fire_cyc[0], fire_cyc[1]); end
   endtask

   task automatic test_straddle();
      exp_t e;
      int   wide_cyc = -1;
      fill_mem();
      mem[0] = 32'h0093_4505;
      mem[1] = 32'h4505_00A0;
      lat = 1;
      do_reset();
      push_expect(32'h0000_4505, 32'h0, 1'b1);
      push_expect(32'h00A0_0093, 32'h2, 1'b0);
      push_expect(32'h0000_4505, 32'h6, 1'b1);
      push_expect(mem[2], 32'h8, 1'b0);
      for (int c = 0; c < 40 && sb.size() > 0; c++) begin
         @(negedge clk);
         if (c == 3) begin
            checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL strad_half_valid got %b expected 0", bus.instr_valid); end
         end
         if (bus.instr_valid && bus.instr_ready) begin
            if (bus.instr_pc == 32'h2) wide_cyc = c;
            checks++;
            if (sb.size() == 0) begin
               errors++; $display("FAIL strad_extra got pc=%h expected no output", bus.instr_pc);
            end else begin
               e = sb.pop_front();
               if (bus.instr !== e.ins || bus.instr_pc !== e.pc || bus.is_compressed !== e.comp) begin
                  errors++; $display("FAIL strad_out got instr=%h pc=%h c=%b expected instr=%h pc=%h c=%b",
                                     bus.instr, bus.instr_pc, bus.is_compressed, e.ins, e.pc, e.comp);
               end
            end
         end
         @(posedge clk); #2;
      end
      checks++; if (sb.size() != 0) begin errors++; $display("FAIL strad_drain got %0d left expected 0", sb.size()); end
      checks++; if (wide_cyc != 4) begin errors++; $display("FAIL strad_timing got cycle %0d expected 4", wide_cyc); end
   endtask

   task automatic test_redirect_outstanding();
      exp_t e;
      bit   plan = 1'b0;
      bit   done = 1'b0;
      bit   seen = 1'b0;
      int   rcyc = -100;
      fill_mem();
      mem[2]  = 32'hDEAD_BEEF;
      mem[64] = 32'h4505_1111;
      mem[65] = 32'h00A0_0093;
      lat = 3;
      do_reset();
      push_expect(mem[0], 32'h0, 1'b0);
      push_expect(mem[1], 32'h4, 1'b0);
      push_expect(32'h0000_4505, 32'h102, 1'b1);
      push_expect(32'h00A0_0093, 32'h104, 1'b0);
      push_expect(mem[66], 32'h108, 1'b0);
      for (int c = 0; c < 80 && sb.size() > 0; c++) begin
         @(negedge clk);
         if (c == rcyc) begin
            checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL redir_cycle_req got %b expected 0", bus.mem_req); end
         end
         if (done && !seen && bus.mem_req) begin
            seen = 1'b1;
            checks++;
            if (bus.mem_addr !== 32'h100 || c != rcyc + 3) begin
               errors++; $display("FAIL redir_next_req got addr=%h cycle=%0d expected addr=100 cycle=%0d", bus.mem_addr, c, rcyc + 3);
            end
         end
         if (!done && bus.mem_req && bus.mem_addr == 32'h8) plan = 1'b1;
         if (bus.instr_valid && bus.instr_ready) begin
            checks++;
            if (sb.size() == 0) begin
               errors++; $display("FAIL redir_extra got pc=%h expected no output", bus.instr_pc);
            end else begin
               e = sb.pop_front();
               if (bus.instr !== e.ins || bus.instr_pc !== e.pc || bus.is_compressed !== e.comp) begin
                  errors++; $display("FAIL redir_out got instr=%h pc=%h c=%b expected instr=%h pc=%h c=%b",
                                     bus.instr, bus.instr_pc, bus.is_compressed, e.ins, e.pc, e.comp);
               end
            end
         end
         @(posedge clk); #2;
         bus.redirect    = plan;
         bus.redirect_pc = 32'h102;
         if (plan) begin
            plan = 1'b0;
            done = 1'b1;
            rcyc = c + 1;
         end
      end
      bus.redirect = 1'b0;
      checks++; if (sb.size() != 0 || !seen) begin
         errors++; $display("FAIL redir_drain got %0d left seen=%b expected 0 left seen=1", sb.size(), seen); end
      lat = 1;
   endtask

   task automatic test_backpressure();
      exp_t e;
      int   reqs = 0;
      int   late = 0;
      fill_mem();
      lat = 1;
      do_reset();
      bus.instr_ready = 1'b0;
      for (int i = 0; i < 10; i++) push_expect(mem[i], 32'(4 * i), 1'b0);
      for (int c = 0; c < 100 && sb.size() > 0; c++) begin
         @(negedge clk);
         if (c < 12 && bus.mem_req) begin
            reqs++;
            if (c >= 7) late++;
         end
         if (c == 11) begin
            checks++; if (reqs != 4 || late != 0) begin
               errors++; $display("FAIL bp_reqs got %0d (late %0d) expected 4 (late 0)", reqs, late); end
            checks++; if (dut.count !== 4'd8) begin errors++; $display("FAIL bp_count got %0d expected 8", dut.count); end
            checks++; if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL bp_valid got %b expected 1", bus.instr_valid); end
         end
         if (bus.instr_valid && bus.instr_ready) begin
            checks++;
            if (sb.size() == 0) begin
               errors++; $display("FAIL bp_extra got pc=%h expected no output", bus.instr_pc);
            end else begin
               e = sb.pop_front();
               if (bus.instr !== e.ins || bus.instr_pc !== e.pc || bus.is_compressed !== e.comp) begin
                  errors++; $display("FAIL bp_out got instr=%h pc=%h c=%b expected instr=%h pc=%h c=%b",
                                     bus.instr, bus.instr_pc, bus.is_compressed, e.ins, e.pc, e.comp);
               end
            end
         end
         @(posedge clk); #2;
         bus.instr_ready = (c + 1 >= 12);
      end
      checks++; if (sb.size() != 0) begin errors++; $display("FAIL bp_drain got %0d left expected 0", sb.size()); end
   endtask

   task automatic test_redirect_rvalid();
      exp_t e;
      fill_mem();
      mem[0]  = 32'hDEAD_BEEF;
      mem[64] = 32'h00A0_0093;
      mem[65] = 32'h4505_4505;
      lat = 1;
      do_reset();
      push_expect(32'h00A0_0093, 32'h100, 1'b0);
      push_expect(32'h0000_4505, 32'h104, 1'b1);
      push_expect(32'h0000_4505, 32'h106, 1'b1);
      @(negedge clk);
      checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0) begin
         errors++; $display("FAIL rvr_c0_req got req=%b addr=%h expected req=1 addr=0", bus.mem_req, bus.mem_addr); end
      @(posedge clk); #2;
      bus.redirect    = 1'b1;
      bus.redirect_pc = 32'h100;
      @(negedge clk);
      checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL rvr_c1_req got %b expected 0", bus.mem_req); end
      @(posedge clk); #2;
      bus.redirect = 1'b0;
      for (int c = 2; c < 40 && sb.size() > 0; c++) begin
         @(negedge clk);
         if (c == 2) begin
            checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h100) begin
               errors++; $display("FAIL rvr_next_req got req=%b addr=%h expected req=1 addr=100", bus.mem_req, bus.mem_addr); end
         end
         if (bus.instr_valid && bus.instr_ready) begin
            checks++;
            if (sb.size() == 0) begin
               errors++; $display("FAIL rvr_extra got pc=%h expected no output", bus.instr_pc);
            end else begin
               e = sb.pop_front();
               if (bus.instr !== e.ins || bus.instr_pc !== e.pc || bus.is_compressed !== e.comp) begin
                  errors++; $display("FAIL rvr_out got instr=%h pc=%h c=%b expected instr=%h pc=%h c=%b",
                                     bus.instr, bus.instr_pc, bus.is_compressed, e.ins, e.pc, e.comp);
               end
            end
         end
         @(posedge clk); #2;
      end
      checks++; if (sb.size() != 0) begin errors++; $display("FAIL rvr_drain got %0d left expected 0", sb.size()); end
   endtask

   task automatic test_reset_mid();
      exp_t e;
      fill_mem();
      lat = 1;
      do_reset();
      bus.instr_ready = 1'b0;
      repeat (9) @(negedge clk);
      checks++; if (bus.instr_valid !== 1'b1) begin errors++; $display("FAIL rmid_pre_valid got %b expected 1", bus.instr_valid); end
      #2;
      rst = 1'b0;
      #1;
      checks++; if (bus.instr_valid !== 1'b0 || bus.mem_req !== 1'b0 || bus.instr_pc !== 32'h0) begin
         errors++; $display("FAIL rmid_async got valid=%b req=%b pc=%h expected valid=0 req=0 pc=0",
                            bus.instr_valid, bus.mem_req, bus.instr_pc); end
      @(posedge clk); #2;
      rst = 1'b1;
      bus.instr_ready = 1'b1;
      push_expect(mem[0], 32'h0, 1'b0);
      push_expect(mem[1], 32'h4, 1'b0);
      for (int c = 0; c < 40 && sb.size() > 0; c++) begin
         @(negedge clk);
         if (c == 0) begin
            checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0) begin
               errors++; $display("FAIL rmid_restart_req got req=%b addr=%h expected req=1 addr=0", bus.mem_req, bus.mem_addr); end
         end
         if (bus.instr_valid && bus.instr_ready) begin
            checks++;
            if (sb.size() == 0) begin
               errors++; $display("FAIL rmid_extra got pc=%h expected no output", bus.instr_pc);
            end else begin
               e = sb.pop_front();
               if (bus.instr !== e.ins || bus.instr_pc !== e.pc || bus.is_compressed !== e.comp) begin
                  errors++; $display("FAIL rmid_out got instr=%h pc=%h c=%b expected instr=%h pc=%h c=%b",
                                     bus.instr, bus.instr_pc, bus.is_compressed, e.ins, e.pc, e.comp);
               end
            end
         end
         @(posedge clk); #2;
      end
      checks++; if (sb.size() != 0) begin errors++; $display("FAIL rmid_drain got %0d left expected 0", sb.size()); end
   endtask

   initial begin
      rst             = 1'b0;
      bus.redirect    = 1'b0;
      bus.redirect_pc = '0;
      bus.instr_ready = 1'b1;
      fill_mem();
      test_reset();
      test_single();
      test_compressed();
      test_straddle();
      test_redirect_outstanding();
      test_backpressure();
      test_redirect_rvalid();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_align_buffer.md
# fetch_align_buffer

Instruction fetch front-end between the instruction memory port and the IF/ID register. It fetches 32-bit words and holds them as 16-bit halfwords in a queue. It realigns mixed 16/32-bit RISC-V instructions, including 32-bit instructions that straddle a word boundary. It delivers one raw instruction per cycle, with its PC and compressed flag, to the decompressor/IF_ID path, and accepts branch/jump redirects from EX.

## Interface
- DEPTH, 8, queue capacity in halfwords (even, ≥4)
- RESET_PC, 32'h0000_0000, PC fetched after reset
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-low reset
- mem_req  output  1  single-cycle fetch request pulse
- mem_addr  output  32  word-aligned fetch address, valid with mem_req
- mem_rvalid  input  1  fetch data valid; returns ≥1 cycle after mem_req
- mem_rdata  input  32  fetched word, little-endian halfwords
- redirect  input  1  taken branch/jump (PCSrc)
- redirect_pc  input  32  target PC, halfword-aligned
- instr_ready  input  1  IF/ID accepts (IF_ID_WriteEN)
- instr_valid  output  1  complete instruction at queue head
- instr  output  32  raw instruction; compressed → {16'b0, hw}
- instr_pc  output  32  PC of instr
- is_compressed  output  1  head halfword [1:0] != 2'b11

## Operation
- State registers:
  - hw queue[DEPTH] with head/tail/count
  - fetch_addr (word-aligned)
  - out_pc
  - outstanding flag
  - discard flag
  - drop_low flag
- Request issue:
  - Condition: !outstanding && count ≤ DEPTH-2 && !redirect.
  - Drives mem_req=1, mem_addr=fetch_addr.
  - Sets outstanding and advances fetch_addr by 4.
- Response handling (mem_rvalid):
  - Clears outstanding.
  - If discard is set: the data is dropped and discard is cleared.
  - Otherwise, if drop_low is set: only mem_rdata[31:16] is pushed and drop_low is cleared.
  - Otherwise: [15:0] then [31:16] are pushed.
- Output decode:
  - The head halfword hw0 determines the instruction type.
  - If hw0[1:0] != 11: compressed, needs count ≥1.
  - Otherwise: 32-bit, needs count ≥2, and instr = {hw1, hw0}.
  - instr_valid = the required halfwords are present.
- Pop (instr_valid && instr_ready):
  - Removes 1 or 2 halfwords.
  - Advances out_pc by 2 or 4 (32-bit wrap).
- Push and pop in the same cycle are both performed; the count update is net.
- Redirect has priority over push, pop and issue in its cycle:
  - Queue emptied (count=0).
  - out_pc ← redirect_pc; fetch_addr ← {redirect_pc[31:2],2'b00}; drop_low ← redirect_pc[1].
  - If outstanding, or if mem_rvalid is high in the same cycle, the response is discarded via the discard flag (same-cycle data is dropped immediately).
  - No request is issued in the redirect cycle.
- Only one request is outstanding at any time.
  - After a redirect with an in-flight request, the next request issues the cycle after the stale response arrives.
- Full: count > DEPTH-2 → no issue. Because of the reservation rule, the queue never overflows.
- Empty, or only a lone half of a 32-bit instruction present → instr_valid=0.
- redirect_pc[0] is ignored.

## Timing
- Reset values:
  - mem_req=0, mem_addr=0, instr_valid=0, instr=0, instr_pc=RESET_PC, is_compressed=0.
  - count=0, fetch_addr=RESET_PC, flags=0.
- The first mem_req is in the first cycle after rst deasserts.
- Outputs are combinational from queue registers only; there is no combinational path from mem_rdata or redirect to instr*.
  - With 1-cycle memory: req in C0, rvalid in C1, instr_valid in C2.
- Sustained throughput with 1-cycle memory: one 32-bit instruction every 2 cycles, or one compressed instruction per cycle.
- Asserting rst mid-operation clears everything immediately. Any response arriving after rst deasserts with no request issued is ignored (outstanding=0).

## Test plan
- Reset then run with 1-cycle memory; word@0 = 0x00A00093; instr_ready=1.
  - Expect mem_req/mem_addr=0 in C0.
  - Expect instr_valid in C2 with instr=0x00A00093, instr_pc=0, is_compressed=0.
- Compressed pair, word@0 = 0x4505_4505.
  - Expect two consecutive outputs 0x0000_4505, at pc 0 and pc 2, both with is_compressed=1.
- Straddling instruction: word@0 = 0x0093_4505, word@4 = 0x4505_00A0.
  - Expect 0x4505@0, then 0x00A00093@2 (instr_valid only after word@4 arrives), then 0x4505@6.
- Redirect to 0x102 while a request to 0x8 is outstanding, with a 3-cycle latency.
  - The stale word is dropped.
  - The next mem_addr is 0x100.
  - The first output has instr_pc=0x102 with data from word@0x100[31:16].
- Backpressure: instr_ready=0 for 12 cycles with a stream of 32-bit instructions.
  - count reaches 8; mem_req stays 0 while count > 6.
  - After release, pcs are 0,4,8,… with no loss or duplication.
- Redirect and mem_rvalid in the same cycle: the data is dropped and the next request is to the new target.
- Drop rst mid-stream: instr_valid=0 asynchronously, and fetching restarts at RESET_PC.
